// File: rtl/i2s_pcm_receiver_pkg.sv
// Shared definitions for the I2S PCM receiver: FSM state codes, the PCM
// word width used by the front-end mux, and a small state-decode helper.
package i2s_pcm_receiver_pkg;

  localparam int PCM_WIDTH = 24;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ALIGN = 2'd1;
  localparam logic [1:0] ST_LEFT  = 2'd2;
  localparam logic [1:0] ST_RIGHT = 2'd3;

  // Aligned to the frame structure: capturing either channel.
  function automatic logic is_locked(input logic [1:0] st);
    return (st == ST_LEFT) || (st == ST_RIGHT);
  endfunction

endpackage

// File: rtl/i2s_pcm_receiver_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin followed by a registered
// rising-edge detector. The rise pulse lags the pin by SYNC_STAGES+1 clocks.
module i2s_pcm_receiver_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;

  // Synchronise the pin and register a one-clock pulse on each 0->1 change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/i2s_pcm_receiver.sv
// I2S stereo deserialiser: oversamples BCLK/LRCLK/SDATA in the clk domain,
// captures the first DATA_WIDTH bits (MSB first) of each slot and presents a
// left/right PCM pair with a one-clock pcm_valid strobe after each right slot.
module i2s_pcm_receiver
  import i2s_pcm_receiver_pkg::*;
#(
  parameter int DATA_WIDTH  = PCM_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic                  i2s_bclk,
  input  logic                  i2s_lrclk,
  input  logic                  i2s_data,
  output logic                  pcm_valid,
  output logic [DATA_WIDTH-1:0] l_pcm_data,
  output logic [DATA_WIDTH-1:0] r_pcm_data,
  output logic                  frame_err,
  output logic                  locked
);

  localparam logic [CNT_WIDTH-1:0] DW_CNT  = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic bclk_rise_s;

  i2s_pcm_receiver_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (i2s_bclk),
    .rise_o  (bclk_rise_s)
  );

  // LRCLK and data get one extra stage so they line up with the registered
  // bclk rise and present the values the pins held at that bclk edge.
  logic [SYNC_STAGES:0] lr_sync_q;
  logic [SYNC_STAGES:0] dat_sync_q;
  logic                 lrclk_s;
  logic                 data_s;

  // Synchronise word select and serial data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lr_sync_q  <= '0;
      dat_sync_q <= '0;
    end else begin
      lr_sync_q  <= {lr_sync_q[SYNC_STAGES-1:0], i2s_lrclk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-1:0], i2s_data};
    end
  end

  assign lrclk_s = lr_sync_q[SYNC_STAGES];
  assign data_s  = dat_sync_q[SYNC_STAGES];

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  lr_prev_q, lr_prev_d;
  logic [DATA_WIDTH-1:0] l_hold_q, l_hold_d;
  logic [DATA_WIDTH-1:0] l_pcm_q, l_pcm_d;
  logic [DATA_WIDTH-1:0] r_pcm_q, r_pcm_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  locked_q, locked_d;
  logic [CNT_WIDTH-1:0]  cnt_inc_s;
  logic                  boundary_s;

  // The count used to judge a closing slot already includes the bit at E.
  assign cnt_inc_s  = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
  assign boundary_s = bclk_rise_s & (lrclk_s ^ lr_prev_q);

  // Slot tracking runs in every state so ALIGN sees genuine boundaries after
  // a run toggle; the FSM decides what a closing slot means.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    lr_prev_d = lr_prev_q;
    l_hold_d  = l_hold_q;
    l_pcm_d   = l_pcm_q;
    r_pcm_d   = r_pcm_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    if (bclk_rise_s) begin
      if (cnt_q < DW_CNT) begin
        shift_d = {shift_q[DATA_WIDTH-2:0], data_s};
      end else begin
        shift_d = shift_q;
      end
      if (boundary_s) begin
        cnt_d     = '0;
        lr_prev_d = lrclk_s;
      end else begin
        cnt_d = cnt_inc_s;
      end
    end else begin
      cnt_d = cnt_q;
    end

    if (!run) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ALIGN;
        ST_ALIGN: begin
          if (boundary_s && !lrclk_s) begin
            state_d = ST_LEFT;
          end else begin
            state_d = ST_ALIGN;
          end
        end
        ST_LEFT: begin
          if (boundary_s) begin
            if (cnt_inc_s >= DW_CNT) begin
              l_hold_d = shift_d;
              state_d  = ST_RIGHT;
            end else begin
              err_d   = 1'b1;
              state_d = ST_ALIGN;
            end
          end else begin
            state_d = ST_LEFT;
          end
        end
        ST_RIGHT: begin
          if (boundary_s) begin
            if (cnt_inc_s >= DW_CNT) begin
              l_pcm_d = l_hold_q;
              r_pcm_d = shift_d;
              valid_d = 1'b1;
              state_d = ST_LEFT;
            end else begin
              err_d   = 1'b1;
              state_d = ST_ALIGN;
            end
          end else begin
            state_d = ST_RIGHT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    locked_d = is_locked(state_d);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      lr_prev_q <= 1'b0;
      l_hold_q  <= '0;
      l_pcm_q   <= '0;
      r_pcm_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      lr_prev_q <= lr_prev_d;
      l_hold_q  <= l_hold_d;
      l_pcm_q   <= l_pcm_d;
      r_pcm_q   <= r_pcm_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      locked_q  <= locked_d;
    end
  end

  assign pcm_valid  = valid_q;
  assign frame_err  = err_q;
  assign locked     = locked_q;
  assign l_pcm_data = l_pcm_q;
  assign r_pcm_data = r_pcm_q;

endmodule

// File: tb/tb_i2s_pcm_receiver.sv
// Self-checking bench for i2s_pcm_receiver: table-driven frame scenarios,
// hand-written run-drop and async-reset sequences, and randomised streams
// checked against a slot-level reference model.
module tb_i2s_pcm_receiver;

  localparam int DW = 24;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset_n, run, i2s_bclk, i2s_lrclk, i2s_data;
  logic          pcm_valid, frame_err, locked;
  logic [DW-1:0] l_pcm_data, r_pcm_data;

  i2s_pcm_receiver #(.DATA_WIDTH(DW), .SYNC_STAGES(SS), .CNT_WIDTH(6)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .i2s_bclk(i2s_bclk),
    .i2s_lrclk(i2s_lrclk), .i2s_data(i2s_data), .pcm_valid(pcm_valid),
    .l_pcm_data(l_pcm_data), .r_pcm_data(r_pcm_data),
    .frame_err(frame_err), .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct { logic lr; int nbits; logic [23:0] word; } slot_t;
  typedef struct { logic err; logic [23:0] l; logic [23:0] r; } ev_t;
  typedef struct {
    int div; int slen; logic [23:0] l; logic [23:0] r;
    int nfr; int trunc_fr; int exp_valid; int exp_err;
  } vec_t;

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    last_rise_cyc = 0;
  int    rise_cnt = 0;
  logic  mon_en = 1'b0;
  logic  prev_valid = 1'b0;
  slot_t slots[$];
  ev_t   exp_q[$];
  ev_t   obs_q[$];
  int    lat_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: collects events and checks strobe properties.
  always @(negedge clk) begin
    if (mon_en) begin
      if (pcm_valid || frame_err)
        check("valid_err_exclusive", {63'd0, pcm_valid & frame_err}, 64'd0);
      if (pcm_valid) begin
        check("valid_one_clk", {63'd0, prev_valid}, 64'd0);
        obs_q.push_back('{1'b0, l_pcm_data, r_pcm_data});
        lat_q.push_back(cyc - last_rise_cyc);
      end
      if (frame_err) begin
        check("locked_after_err", {63'd0, locked}, 64'd0);
        obs_q.push_back('{1'b1, 24'h0, 24'h0});
      end
    end
    prev_valid <= pcm_valid;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    mon_en    = 1'b0;
    reset_n   = 1'b0;
    run       = 1'b1;
    i2s_bclk  = 1'b0;
    i2s_lrclk = 1'b0;
    i2s_data  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid",  {63'd0, pcm_valid}, 64'd0);
    check("rst_err",    {63'd0, frame_err}, 64'd0);
    check("rst_locked", {63'd0, locked}, 64'd0);
    check("rst_l",      {40'd0, l_pcm_data}, 64'd0);
    check("rst_r",      {40'd0, r_pcm_data}, 64'd0);
    reset_n = 1'b1;
    obs_q.delete();
    lat_q.delete();
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  // Drives the current slot list; data trails lrclk by one bclk (I2S delay).
  task automatic play(input int div);
    logic lrs[$];
    logic bits[$];
    foreach (slots[i])
      for (int b = 0; b < slots[i].nbits; b++) begin
        lrs.push_back(slots[i].lr);
        bits.push_back((b < 24) ? slots[i].word[23-b] : 1'($urandom_range(0, 1)));
      end
    rise_cnt = 0;
    @(negedge clk);
    for (int k = 0; k < lrs.size(); k++) begin
      i2s_bclk  = 1'b0;
      i2s_lrclk = lrs[k];
      i2s_data  = (k == 0) ? 1'b0 : bits[k-1];
      repeat (div/2) @(negedge clk);
      i2s_bclk      = 1'b1;
      last_rise_cyc = cyc;
      rise_cnt++;
      repeat (div/2) @(negedge clk);
    end
    i2s_bclk = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  // Slot-level reference: a slot is captured only once a right->left
  // transition has been seen; short slots raise an error and force realign.
  task automatic model();
    logic        waiting = 1'b1;
    logic [23:0] lhold = 24'h0;
    exp_q.delete();
    for (int i = 0; i < slots.size() - 1; i++) begin
      if (waiting) begin
        if (slots[i].lr && !slots[i+1].lr) waiting = 1'b0;
      end else if (slots[i].nbits < 24) begin
        exp_q.push_back('{1'b1, 24'h0, 24'h0});
        waiting = 1'b1;
      end else if (!slots[i].lr) begin
        lhold = slots[i].word;
      end else begin
        exp_q.push_back('{1'b0, lhold, slots[i].word});
      end
    end
  endtask

  task automatic compare_events(input string tag);
    int n;
    check({tag, "_nevents"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_ev_err"}, {63'd0, obs_q[i].err}, {63'd0, exp_q[i].err});
      check({tag, "_ev_l"}, {40'd0, obs_q[i].l}, {40'd0, exp_q[i].l});
      check({tag, "_ev_r"}, {40'd0, obs_q[i].r}, {40'd0, exp_q[i].r});
    end
  endtask

  task automatic push_frame(input int ll, input int rl, input logic [23:0] l, input logic [23:0] r);
    slots.push_back('{1'b0, ll, l});
    slots.push_back('{1'b1, rl, r});
  endtask

  vec_t tbl[3];

  initial begin
    tbl[0] = '{16, 32, 24'h123456, 24'hABCDEF, 3, -1, 3, 0};
    tbl[1] = '{4,  24, 24'h800000, 24'h7FFFFF, 3, -1, 3, 0};
    tbl[2] = '{4,  32, 24'h13579B, 24'h2468AC, 4,  2, 2, 1};

    // Table scenarios: stream starts mid right slot, then nfr full frames.
    for (int t = 0; t < 3; t++) begin
      int nv, ne;
      do_reset();
      slots.delete();
      slots.push_back('{1'b1, 5, 24'h0});
      for (int f = 1; f <= tbl[t].nfr; f++)
        push_frame(tbl[t].slen, (f == tbl[t].trunc_fr) ? 20 : tbl[t].slen, tbl[t].l, tbl[t].r);
      slots.push_back('{1'b0, 2, 24'h0});
      model();
      play(tbl[t].div);
      compare_events($sformatf("tbl%0d", t));
      nv = 0; ne = 0;
      foreach (obs_q[i]) begin
        if (obs_q[i].err) ne++;
        else begin
          nv++;
          check("tbl_pair_l", {40'd0, obs_q[i].l}, {40'd0, tbl[t].l});
          check("tbl_pair_r", {40'd0, obs_q[i].r}, {40'd0, tbl[t].r});
        end
      end
      check("tbl_nvalid", nv, tbl[t].exp_valid);
      check("tbl_nerr", ne, tbl[t].exp_err);
      check("tbl_hold_l", {40'd0, l_pcm_data}, {40'd0, tbl[t].l});
      check("tbl_hold_r", {40'd0, r_pcm_data}, {40'd0, tbl[t].r});
      if (tbl[t].div == 16 && lat_q.size() > 0)
        check("latency", lat_q[0], SS + 2);
    end

    // run low for 10 clk in the middle of frame 2's left slot.
    do_reset();
    slots.delete();
    slots.push_back('{1'b1, 5, 24'h0});
    push_frame(32, 32, 24'h123456, 24'hABCDEF);
    push_frame(32, 32, 24'h111111, 24'h222222);
    push_frame(32, 32, 24'h333333, 24'h444444);
    push_frame(32, 32, 24'h555555, 24'h666666);
    slots.push_back('{1'b0, 2, 24'h0});
    exp_q.delete();
    exp_q.push_back('{1'b0, 24'h123456, 24'hABCDEF});
    exp_q.push_back('{1'b0, 24'h333333, 24'h444444});
    exp_q.push_back('{1'b0, 24'h555555, 24'h666666});
    fork
      play(16);
      begin
        for (int w = 0; w < 20000 && rise_cnt < 85; w++) @(negedge clk);
        check("run_drop_reached", {63'd0, rise_cnt >= 85}, 64'd1);
        run = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_locked", {63'd0, locked}, 64'd0);
        check("idle_hold_l", {40'd0, l_pcm_data}, 64'h123456);
        check("idle_hold_r", {40'd0, r_pcm_data}, 64'hABCDEF);
        repeat (8) @(negedge clk);
        run = 1'b1;
      end
    join
    compare_events("rundrop");

    // Asynchronous reset mid-frame, between clock edges.
    fork
      play(16);
      begin
        for (int w = 0; w < 20000 && rise_cnt < 100; w++) @(negedge clk);
        check("areset_reached", {63'd0, rise_cnt >= 100}, 64'd1);
        check("areset_pre_l", {40'd0, l_pcm_data}, 64'h123456);
        check("areset_pre_locked", {63'd0, locked}, 64'd1);
        mon_en = 1'b0;
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("areset_l", {40'd0, l_pcm_data}, 64'd0);
        check("areset_r", {40'd0, r_pcm_data}, 64'd0);
        check("areset_locked", {63'd0, locked}, 64'd0);
        check("areset_valid", {63'd0, pcm_valid}, 64'd0);
      end
    join
    reset_n = 1'b1;

    // Randomised streams against the slot-level model.
    for (int it = 0; it < 8; it++) begin
      int div, ns;
      logic lr;
      do_reset();
      div = 2 * $urandom_range(2, 4);
      lr  = 1'($urandom_range(0, 1));
      slots.delete();
      slots.push_back('{lr, $urandom_range(1, 30), 24'($urandom)});
      ns = $urandom_range(8, 12);
      for (int s = 0; s < ns; s++) begin
        lr = ~lr;
        slots.push_back('{lr,
          ($urandom_range(0, 6) == 0) ? $urandom_range(8, 23) : $urandom_range(24, 40),
          24'($urandom)});
      end
      slots.push_back('{~lr, 2, 24'h0});
      model();
      play(div);
      compare_events($sformatf("rand%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_pcm_receiver.md
Name: i2s_pcm_receiver

Overview:
Deserialises a standard I2S stereo stream (BCLK, LRCLK, SDATA from the ADC/SPDIF receiver) into parallel 24-bit left/right PCM words. Produces the pcm_valid strobe and l_pcm_data/r_pcm_data bus that the front-end test/bypass mux consumes directly upstream of the filter chain.
All I2S pins are oversampled and synchronised in the mclk (clk) domain. No second clock domain exists inside the block.

Parameters:
DATA_WIDTH, 24, PCM word width captured per channel (MSB first, left-justified in slot)
SYNC_STAGES, 2, synchroniser flops on i2s_bclk/i2s_lrclk/i2s_data (min 2)
CNT_WIDTH, 6, slot bit counter width; saturates at 2^CNT_WIDTH-1

Ports:
clk  in  1  master clock (49.152 MHz), must be >= 4x bclk
reset_n  in  1  asynchronous active-low reset
run  in  1  enable; low = synchronous return to IDLE
i2s_bclk  in  1  asynchronous serial bit clock
i2s_lrclk  in  1  asynchronous word select, 0 = left, 1 = right
i2s_data  in  1  asynchronous serial data
pcm_valid  out  1  one-clk strobe, new stereo pair on l/r_pcm_data
l_pcm_data  out  DATA_WIDTH  left sample, two's complement, held between strobes
r_pcm_data  out  DATA_WIDTH  right sample, held between strobes
frame_err  out  1  one-clk strobe, slot shorter than DATA_WIDTH bits
locked  out  1  high once aligned (state LEFT or RIGHT)

Behaviour:
- Reset (async, reset_n=0): all outputs 0, shift reg/hold reg/counters 0, state IDLE. Synchronisers cleared.
- Sync: each I2S pin goes through SYNC_STAGES flops. bclk_rise = synced bclk 0->1 (one extra flop for edge detect). All logic advances only on clk cycles with bclk_rise.
- Per bclk_rise, in this order:
  (a) if bit_cnt < DATA_WIDTH, shift_reg <= {shift_reg[DW-2:0], data_s};
  (b) bit_cnt <= bit_cnt+1, saturating;
  (c) if lrclk_s != lr_prev (slot boundary E), the bit sampled at E is the last bit of the old slot (I2S one-bit delay). Close the old slot using the updated count, then bit_cnt <= 0 and lr_prev <= lrclk_s.
- Slots longer than DATA_WIDTH: extra bits ignored (16/24/32-bit slots are all legal if >= DATA_WIDTH).
- States:
  - IDLE: run=0. Go to ALIGN when run=1.
  - ALIGN: discard data. On the first boundary with lrclk 1->0, go to LEFT.
  - LEFT: on 0->1 boundary, close the slot. If count >= DW, l_hold <= shift_reg and go to RIGHT. Otherwise pulse frame_err and go to ALIGN.
  - RIGHT: on 1->0 boundary, close the slot. If count >= DW, l_pcm_data <= l_hold, r_pcm_data <= shift_reg, pulse pcm_valid, and go to LEFT. Otherwise pulse frame_err and go to ALIGN.
- Latency: pcm_valid is asserted the clk cycle after bclk_rise for the right-slot closing edge, i.e. SYNC_STAGES+2 clk after the i2s_bclk pin rise. Output data changes in that same cycle.
- pcm_valid and frame_err are never high together. Each is high exactly 1 clk per event.
- run deassert mid-frame: next clk state goes to IDLE, the partial frame is discarded, pcm_valid=0, l/r_pcm_data hold their last values. On re-assert, the block realigns via ALIGN; no stale l_hold is ever emitted.
- locked = (state==LEFT || state==RIGHT).
- lrclk toggling without bclk has no effect; boundaries are sampled only on bclk_rise.

Decomposition:
- Shared package (audio_pkg): state enum {IDLE, ALIGN, LEFT, RIGHT}; PCM_WIDTH=24 constant reused by the front-end mux.
- One natural sub-module: i2s_sync_edge (SYNC_STAGES synchroniser plus rise detector), instantiated for bclk; lrclk/data use synchroniser only.

Test Plan:
- 64-bclk frame (32-bit slots), bclk=clk/16, L=0x123456, R=0xABCDEF -> after one alignment frame, pcm_valid 1-clk pulses with l=0x123456, r=0xABCDEF, exactly one pulse per frame.
- 48-bclk frame (24-bit slots), L=0x800000, R=0x7FFFFF, bclk=clk/4 -> l=0x800000, r=0x7FFFFF, no frame_err.
- Right slot truncated to 20 bits -> frame_err pulse, no pcm_valid for that frame, locked drops. The next full frame after the following 1->0 boundary outputs correct data.
- Start stream mid-right-slot after reset -> no pcm_valid until the first complete left+right pair; the first output equals the second frame's values.
- run low for 10 clk mid-left-slot, then high -> state IDLE, outputs hold previous 0x123456/0xABCDEF, resumes after realign, no corrupted pair emitted.
- reset_n asserted mid-frame, asynchronously (no clk edge) -> outputs immediately 0, locked=0.
